// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART shared state encodings, defaults and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // Parity bit a transmitter would send for the low nb bits of data.
    function automatic logic parity_calc(input logic [8:0] data, input int nb, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 9; i++) begin
            if (i < nb) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word channel from the UART receiver to the RX FIFO
interface uart_rx_cfg_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done_tick;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_busy;

    modport master (output o_data, o_rx_done_tick, o_parity_err, o_frame_err, o_busy);
    modport slave  (input  o_data, o_rx_done_tick, o_parity_err, o_frame_err, o_busy);
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampled UART receiver with parity, framing and break handling
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int N_STOP     = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_rx,
    uart_rx_cfg_if.master rx_out
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(NB_DATA);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
    localparam logic          STOP_LAST = 1'(N_STOP - 1);

    uart_rx_state_t     state;
    logic [SW-1:0]      s;
    logic [NW-1:0]      n;
    logic               stop_cnt;
    logic [NB_DATA-1:0] sh;
    logic               perr;
    logic               ferr;
    logic               rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // o_busy is updated on every transition so it always mirrors the state being entered.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state                 <= IDLE;
            s                     <= '0;
            n                     <= '0;
            stop_cnt              <= 1'b0;
            sh                    <= '0;
            perr                  <= 1'b0;
            ferr                  <= 1'b0;
            rx_out.o_data         <= '0;
            rx_out.o_rx_done_tick <= 1'b0;
            rx_out.o_parity_err   <= 1'b0;
            rx_out.o_frame_err    <= 1'b0;
            rx_out.o_busy         <= 1'b0;
        end else begin
            rx_out.o_rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state         <= START;
                        s             <= '0;
                        perr          <= 1'b0;
                        ferr          <= 1'b0;
                        rx_out.o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s == S_MID) begin
                            if (rx_s) begin
                                state         <= IDLE;
                                rx_out.o_busy <= 1'b0;
                            end else begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s == S_END) begin
                            s  <= '0;
                            sh <= {rx_s, sh[NB_DATA-1:1]};
                            if (n == N_LAST) begin
                                state    <= (PARITY_EN != 0) ? PARITY : STOP;
                                stop_cnt <= 1'b0;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (i_tick) begin
                        if (s == S_END) begin
                            s        <= '0;
                            perr     <= parity_calc(9'(sh), NB_DATA, PARITY_ODD != 0) ^ rx_s;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (s == S_END) begin
                            s <= '0;
                            if (!rx_s) ferr <= 1'b1;
                            if (stop_cnt == STOP_LAST) begin
                                rx_out.o_data         <= sh;
                                rx_out.o_parity_err   <= (PARITY_EN != 0) ? perr : 1'b0;
                                rx_out.o_frame_err    <= ferr | ~rx_s;
                                rx_out.o_rx_done_tick <= 1'b1;
                                if (ferr | ~rx_s) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    state         <= IDLE;
                                    rx_out.o_busy <= 1'b0;
                                end
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state         <= IDLE;
                        rx_out.o_busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    rx_out.o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg over three frame formats
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    int   tick_cnt = 0;
    logic rx_line [3];

    int n_checks = 0;
    int n_errors = 0;

    // dut0: 8N1 x16, dut1: 8E2 x16, dut2: 7O1 x8
    int cfg_nb   [3] = '{8, 8, 7};
    int cfg_os   [3] = '{16, 16, 8};
    int cfg_pen  [3] = '{0, 1, 1};
    int cfg_podd [3] = '{0, 0, 1};
    int cfg_ns   [3] = '{1, 2, 1};

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
        tick     <= (tick_cnt == 3);
    end

    uart_rx_cfg_if #(.NB_DATA(8)) a_if ();
    uart_rx_cfg_if #(.NB_DATA(8)) b_if ();
    uart_rx_cfg_if #(.NB_DATA(7)) c_if ();

    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .N_STOP(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_line[0]), .rx_out(a_if));
    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .N_STOP(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_line[1]), .rx_out(b_if));
    uart_rx_cfg #(.NB_DATA(7), .OVERSAMPLE(8), .N_STOP(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx_line[2]), .rx_out(c_if));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int idx, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_done dut%0d: got data=%h perr=%b ferr=%b, required no pulse", idx, d, pe, fe);
        end else begin
            e = exp_q.pop_front();
            if (e.idx != idx || e.data !== d || e.perr !== pe || e.ferr !== fe) begin
                n_errors++;
                $display("FAIL frame dut%0d: got data=%h perr=%b ferr=%b, required dut%0d data=%h perr=%b ferr=%b",
                         idx, d, pe, fe, e.idx, e.data, e.perr, e.ferr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.o_rx_done_tick) check_out(0, 9'(a_if.o_data), a_if.o_parity_err, a_if.o_frame_err);
            if (b_if.o_rx_done_tick) check_out(1, 9'(b_if.o_data), b_if.o_parity_err, b_if.o_frame_err);
            if (c_if.o_rx_done_tick) check_out(2, 9'(c_if.o_data), c_if.o_parity_err, c_if.o_frame_err);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic drive_bit(input int idx, input logic val);
        rx_line[idx] = val;
        wait_ticks(cfg_os[idx]);
    endtask

    // Reference: expected word is the low nb bits; parity error when the count of ones
    // over data plus parity bit has the wrong oddness; frame error when any stop bit is 0.
    task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        e.idx  = idx;
        e.data = data & ((9'd1 << cfg_nb[idx]) - 9'd1);
        ones   = $countones(e.data) + int'(pbit);
        e.perr = (cfg_pen[idx] != 0) && ((ones % 2) != cfg_podd[idx]);
        e.ferr = !stops[0] || (cfg_ns[idx] == 2 && !stops[1]);
        exp_q.push_back(e);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < cfg_nb[idx]; i++) drive_bit(idx, e.data[i]);
        if (cfg_pen[idx] != 0) drive_bit(idx, pbit);
        for (int j = 0; j < cfg_ns[idx]; j++) drive_bit(idx, stops[j]);
    endtask

    initial begin
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;
        int         idx;

        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data_a", 32'(a_if.o_data), 0);
        chk("reset_done_a", 32'(a_if.o_rx_done_tick), 0);
        chk("reset_flags_b", {30'd0, b_if.o_parity_err, b_if.o_frame_err}, 0);
        chk("reset_busy_c", 32'(c_if.o_busy), 0);
        rst = 1'b0;
        wait_ticks(16);

        send_frame(0, 9'h055, 1'b0, 2'b11);
        rx_line[0] = 1'b1;
        wait_ticks(16);
        chk("busy_after_8n1", 32'(a_if.o_busy), 0);

        send_frame(1, 9'h0A3, 1'b1, 2'b11);
        send_frame(1, 9'h0A3, 1'b0, 2'b11);
        rx_line[1] = 1'b1;
        wait_ticks(16);

        // second stop bit low, then the line stays low as a break
        send_frame(1, 9'h03C, 1'b0, 2'b01);
        wait_ticks(3 * 12 * 16);
        chk("busy_in_break", 32'(b_if.o_busy), 1);
        rx_line[1] = 1'b1;
        wait_ticks(16);
        chk("busy_after_break", 32'(b_if.o_busy), 0);
        send_frame(1, 9'h081, 1'b0, 2'b11);
        rx_line[1] = 1'b1;
        wait_ticks(16);

        rx_line[0] = 1'b0;
        wait_ticks(5);
        chk("busy_during_glitch", 32'(a_if.o_busy), 1);
        rx_line[0] = 1'b1;
        wait_ticks(16);
        chk("busy_after_glitch", 32'(a_if.o_busy), 0);

        drive_bit(0, 1'b0);
        rx_line[0] = 1'b1;
        wait_ticks(20);
        chk("busy_mid_data", 32'(a_if.o_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_data_a", 32'(a_if.o_data), 0);
        chk("midreset_busy_a", 32'(a_if.o_busy), 0);
        chk("midreset_flags_b", {29'd0, b_if.o_parity_err, b_if.o_frame_err, b_if.o_rx_done_tick}, 0);
        rst = 1'b0;
        wait_ticks(16);
        send_frame(0, 9'h00F, 1'b0, 2'b11);
        rx_line[0] = 1'b1;
        wait_ticks(16);

        send_frame(2, 9'h07F, 1'b0, 2'b11);
        send_frame(2, 9'h000, 1'b1, 2'b11);
        rx_line[2] = 1'b1;
        wait_ticks(16);

        for (int k = 0; k < 30; k++) begin
            idx = int'($urandom_range(0, 2));
            d   = 9'($urandom);
            pb  = 1'($urandom);
            st  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            send_frame(idx, d, pb, st);
            rx_line[idx] = 1'b1;
            wait_ticks(int'($urandom_range(1, 20)));
        end

        wait_ticks(32);
        chk("final_busy", {29'd0, a_if.o_busy, b_if.o_busy, c_if.o_busy}, 0);
        chk("frames_outstanding", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
